// File: rtl/result_tx_sequencer.sv
// result_tx_sequencer: streams a captured multi-byte distance result to the
// UART transmitter, least-significant byte first. Each rising edge of
// calc_ready starts one burst. The sequencer uses a start/busy handshake with
// the UART and aborts the burst if the UART does not acknowledge in time.
module result_tx_sequencer #(
  parameter int unsigned N_BYTES     = 3,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       calc_ready,
  input  logic [7:0] aux_result [N_BYTES-1:0],
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       seq_err,
  output logic       overrun
);

  localparam int unsigned IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       buf_q [N_BYTES-1:0];
  logic             capture_c;
  logic             cr_q;
  logic             cr_vld_q;
  logic             rise_c;
  logic             tx_start_d;
  logic [7:0]       tx_data_d;
  logic             seq_err_d;
  logic             overrun_d;

  // cr_vld_q keeps a level that is already high when reset releases from
  // being mistaken for a fresh rising edge.
  assign rise_c    = calc_ready & ~cr_q & cr_vld_q;
  assign idx_nxt_c = idx_q + IDX_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    capture_c  = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    seq_err_d  = 1'b0;
    overrun_d  = rise_c && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (rise_c) begin
          capture_c = 1'b1;
          idx_d     = '0;
          tx_data_d = aux_result[0];
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (!tx_busy) begin
          tx_data_d  = buf_q[idx_q];
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          cnt_d     = cnt_q + CNT_W'(1);
          seq_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == IDX_W'(N_BYTES - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_nxt_c;
            tx_data_d = buf_q[idx_nxt_c];
            state_d   = S_ARM;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath, edge detector and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      cr_q     <= 1'b0;
      cr_vld_q <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
      seq_err  <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < int'(N_BYTES); i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cr_q     <= calc_ready;
      cr_vld_q <= 1'b1;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
      seq_busy <= (state_d != S_IDLE);
      seq_done <= (state_d == S_DONE);
      seq_err  <= seq_err_d;
      overrun  <= overrun_d;
      if (capture_c) begin
        for (int i = 0; i < int'(N_BYTES); i++) begin
          buf_q[i] <= aux_result[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Bench for result_tx_sequencer: UART busy model, output monitor and a
// byte-split reference of the result value, with directed and random bursts.
module tb_result_tx_sequencer;

  localparam int unsigned N_BYTES     = 3;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam int unsigned RW          = 8 * N_BYTES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       calc_ready = 1'b0;
  logic [7:0] aux_result [N_BYTES-1:0];
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       seq_busy;
  logic       seq_done;
  logic       seq_err;
  logic       overrun;

  result_tx_sequencer #(.N_BYTES(N_BYTES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .calc_ready (calc_ready),
    .aux_result (aux_result),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .seq_err    (seq_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model: after a tx_start, optionally delay, then hold busy for busy_len cycles
  int   ack_dly  = 0;
  int   busy_len = 10;
  logic uart_en  = 1'b1;
  logic uart_act = 1'b0;

  always begin
    @(negedge clk);
    if (tx_start && uart_en) begin
      uart_act = 1'b1;
      repeat (ack_dly) @(negedge clk);
      tx_busy = 1'b1;
      repeat (busy_len) @(negedge clk);
      tx_busy  = 1'b0;
      uart_act = 1'b0;
    end
  end

  // Monitor: records sent bytes and counts every output pulse cycle
  logic [7:0] got [$];
  int n_start = 0, n_done = 0, n_err = 0, n_ovr = 0;
  int cyc = 0, t_start = 0, t_err = 0;

  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      got.push_back(tx_data);
      n_start++;
      t_start = cyc;
    end
    if (seq_done) n_done++;
    if (seq_err) begin
      n_err++;
      t_err = cyc;
    end
    if (overrun) n_ovr++;
  end

  int b_idx, b_start, b_done, b_err, b_ovr;

  task automatic snap();
    b_idx   = got.size();
    b_start = n_start;
    b_done  = n_done;
    b_err   = n_err;
    b_ovr   = n_ovr;
  endtask

  task automatic set_result(input logic [RW-1:0] r);
    for (int i = 0; i < int'(N_BYTES); i++) aux_result[i] = r[8*i +: 8];
  endtask

  task automatic rise();
    @(negedge clk);
    calc_ready = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!seq_busy && !uart_act) break;
    end
    if (i == 3000) check({tag, "_idle_wait"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input string tag, input int k);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (n_start - b_start >= k) break;
      @(negedge clk);
    end
    if (i == 3000) check({tag, "_start_wait"}, 32'd0, 32'd1);
  endtask

  // Reference: one burst of the result value split LSB first, one done, no error
  task automatic expect_burst(input string tag, input logic [RW-1:0] r, input int exp_ovr);
    logic [7:0] eb;
    check({tag, "_nstart"}, 32'(n_start - b_start), N_BYTES);
    for (int i = 0; i < int'(N_BYTES); i++) begin
      eb = 8'(r >> (8 * i));
      if (b_idx + i < got.size()) check($sformatf("%s_byte%0d", tag, i), 32'(got[b_idx + i]), 32'(eb));
      else check($sformatf("%s_byte%0d_missing", tag, i), 32'd0, 32'd1);
    end
    check({tag, "_done"}, 32'(n_done - b_done), 32'd1);
    check({tag, "_err"}, 32'(n_err - b_err), 32'd0);
    check({tag, "_ovr"}, 32'(n_ovr - b_ovr), 32'(exp_ovr));
  endtask

  logic [RW-1:0] r;
  int hold, k, inject;

  initial begin
    set_result('0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({tx_start, tx_data, seq_busy, seq_done, seq_err, overrun}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single burst with latency check
    set_result(24'h05A31C);
    snap();
    @(negedge clk);
    calc_ready = 1'b1;
    @(posedge clk); #1;
    check("lat_edge1_start", 32'(tx_start), 32'd0);
    check("lat_edge1_busy", 32'(seq_busy), 32'd1);
    @(posedge clk); #1;
    check("lat_edge2_start", 32'(tx_start), 32'd1);
    check("lat_edge2_data", 32'(tx_data), 32'h1C);
    @(negedge clk);
    calc_ready = 1'b0;
    wait_idle("single");
    expect_burst("single", 24'h05A31C, 0);

    // Level held high for 200 cycles
    snap();
    rise();
    repeat (200) @(negedge clk);
    calc_ready = 1'b0;
    wait_idle("hold");
    expect_burst("hold", 24'h05A31C, 0);

    // Input change after capture
    snap();
    rise();
    @(negedge clk);
    set_result('1);
    @(negedge clk);
    calc_ready = 1'b0;
    wait_idle("iso");
    expect_burst("iso", 24'h05A31C, 0);

    // Second rise while byte 1 is in flight
    set_result(24'h05A31C);
    snap();
    rise();
    repeat (3) @(negedge clk);
    calc_ready = 1'b0;
    wait_starts("ovr", 2);
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0;
    wait_idle("ovr");
    repeat (20) @(negedge clk);
    expect_burst("ovr", 24'h05A31C, 1);

    // Ack timeout, then a normal burst
    uart_en = 1'b0;
    snap();
    rise();
    repeat (2) @(negedge clk);
    calc_ready = 1'b0;
    wait_idle("to");
    check("to_nstart", 32'(n_start - b_start), 32'd1);
    check("to_err", 32'(n_err - b_err), 32'd1);
    check("to_done", 32'(n_done - b_done), 32'd0);
    check("to_gap", 32'(t_err - t_start), ACK_TIMEOUT);
    check("to_busy", 32'(seq_busy), 32'd0);
    uart_en = 1'b1;
    r = 24'h3B00E7;
    set_result(r);
    snap();
    rise();
    repeat (2) @(negedge clk);
    calc_ready = 1'b0;
    wait_idle("after_to");
    expect_burst("after_to", r, 0);

    // Async reset during byte 1 transmission, calc_ready held high
    set_result(24'h05A31C);
    snap();
    rise();
    for (int i = 0; i < 3000; i++) begin
      if (n_start - b_start >= 2 && tx_busy) break;
      @(negedge clk);
    end
    check("arst_reached", 32'(seq_busy), 32'd1);
    #2 reset = 1'b1;
    #1 check("arst_outputs", 32'({tx_start, tx_data, seq_busy, seq_done, seq_err, overrun}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    snap();
    for (int i = 0; i < 100 && uart_act; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("arst_no_burst", 32'(n_start - b_start), 32'd0);
    check("arst_idle", 32'(seq_busy), 32'd0);
    calc_ready = 1'b0;
    @(negedge clk);
    snap();
    rise();
    repeat (2) @(negedge clk);
    calc_ready = 1'b0;
    wait_idle("arst_next");
    expect_burst("arst_next", 24'h05A31C, 0);

    // Random bursts, some with an overrun rise mid-burst
    for (int it = 0; it < 20; it++) begin
      r        = RW'($urandom);
      busy_len = $urandom_range(1, 12);
      ack_dly  = $urandom_range(0, 4);
      inject   = $urandom_range(0, 1);
      k        = $urandom_range(1, N_BYTES);
      hold     = $urandom_range(1, 3);
      set_result(r);
      snap();
      rise();
      repeat (hold) @(negedge clk);
      calc_ready = 1'b0;
      if (inject != 0) begin
        wait_starts($sformatf("rnd%0d", it), k);
        calc_ready = 1'b1;
        @(negedge clk);
        calc_ready = 1'b0;
      end
      wait_idle($sformatf("rnd%0d", it));
      expect_burst($sformatf("rnd%0d", it), r, inject);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
- Return path of the coprocessor: takes the byte-split distance result (aux_result bytes plus the calc_ready flag from the distance unit) and streams it to the host.
- Sends the bytes one by one to the UART transmitter using a start/busy handshake, least-significant byte first.
- Sends exactly one burst per rising edge of calc_ready.
- Sits between the distance unit and uart_tx.

Parameters:
- N_BYTES, 3: number of result bytes sent per burst (19-bit result → 3).
- ACK_TIMEOUT, 16: maximum cycles to wait for tx_busy to rise after tx_start before aborting.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- calc_ready  in  1  result-valid level from the distance unit; a burst is triggered on its 0→1 edge.
- aux_result  in  8 x N_BYTES (unpacked [N_BYTES-1:0])  result bytes; index 0 is the LSB.
- tx_busy  in  1  UART transmitter busy; high while a byte is shifting out.
- tx_start  out  1  one-cycle request to the UART to send tx_data.
- tx_data  out  8  byte presented to the UART; stable from tx_start until tx_busy falls.
- seq_busy  out  1  high whenever the FSM is not in IDLE.
- seq_done  out  1  one-cycle pulse after the last byte completes.
- seq_err  out  1  one-cycle pulse on ack timeout.
- overrun  out  1  one-cycle pulse when a calc_ready rising edge arrives while seq_busy=1.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; byte index = 0; captured bytes = 0; calc_ready edge register = 0. Reset is asynchronous and can interrupt any state; tx_start drops immediately.
- Edge detect: register calc_ready as cr_q; rise = calc_ready & ~cr_q. A level held high triggers only one burst.
- IDLE:
  - On rise, capture all aux_result bytes into an internal buffer (same cycle), clear idx, go to ARM.
  - Input changes after capture do not affect the burst.
- ARM:
  - If tx_busy = 0: drive tx_data = buf[idx], pulse tx_start for one cycle, clear the timeout counter, go to WAIT_ACK.
  - If tx_busy = 1: stay in ARM.
- WAIT_ACK:
  - If tx_busy = 1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, pulse seq_err and go to IDLE. No seq_done is issued on this path.
- WAIT_DONE:
  - When tx_busy = 0: if idx = N_BYTES-1, go to DONE; else increment idx and go to ARM.
- DONE: pulse seq_done for one cycle, go to IDLE.
- Output timing:
  - tx_data holds buf[idx] from ARM through WAIT_DONE.
  - seq_busy = (state != IDLE).
- Overrun: a rise seen in any state other than IDLE pulses overrun and is otherwise dropped. It does not queue a burst and does not re-capture.
- Rise in the same cycle DONE→IDLE: this counts as busy. overrun pulses and no new burst starts.
- Latency: with tx_busy idle, tx_start asserts 2 cycles after the calc_ready rise (cycle 1: IDLE→ARM; cycle 2: ARM issues tx_start).
- Minimum gap between the tx_busy fall and the next tx_start is 1 cycle.
- Timing: no combinational path from inputs to tx_start or tx_data; both are registered.

Test Plan:
- Single burst: aux_result = {8'h05, 8'hA3, 8'h1C}, i.e. bytes 0x1C, 0xA3, 0x05 (result = 0x5A31C); raise calc_ready; UART model with busy high for 10 cycles per byte → tx_data sequence 0x1C, 0xA3, 0x05; exactly 3 tx_start pulses; one seq_done; tx_start first seen 2 cycles after the rise.
- Level hold: calc_ready held high for 200 cycles → exactly one burst; no overrun.
- Capture isolation: change aux_result to all 0xFF one cycle after the rise → transmitted bytes are still 0x1C, 0xA3, 0x05.
- Overrun: second calc_ready rise while transmitting byte 1 → overrun pulses once; the burst completes with only 3 bytes; no second burst.
- Timeout: UART model never raises tx_busy → seq_err pulses ACK_TIMEOUT = 16 cycles after tx_start; FSM returns to IDLE; the next rise sends a full burst normally.
- Async reset mid-burst: assert reset while in WAIT_DONE on byte 1 → all outputs 0 immediately, before the next clock edge; after release with calc_ready still high, no burst starts until calc_ready falls and rises again.
